// File: rtl/fetch_queue.sv
// In-order show-ahead instruction buffer between fetch and dispatch.
// Absorbs fetched packets during dispatch hazards; flushes completely on squash.
`default_nettype none

package fetch_queue_pkg;
    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic            valid;
        logic [31:0]     inst;
        logic [XLEN-1:0] PC;
        logic [XLEN-1:0] NPC;
    } IF_ID_PACKET;
endpackage

module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  IF_ID_PACKET      if_id_packet_in,
    input  logic             struc_hazard,
    input  logic             squash,
    output IF_ID_PACKET      if_id_packet_out,
    output logic             fetch_stall,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] PC;
        logic [XLEN-1:0] NPC;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  head_reg, head_next;
    logic [PTR_W-1:0]  tail_reg, tail_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              enq, deq;
    logic              empty, full;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CNT_W'(DEPTH));

    // Stall depends only on occupancy: a concurrent dequeue does not free a slot this cycle.
    assign fetch_stall = full;
    assign count       = count_reg;

    assign deq = ~empty & ~struc_hazard & ~squash;
    assign enq = if_id_packet_in.valid & ~full & ~squash;

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (squash) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (deq) begin
                head_next = head_reg + PTR_W'(1);
            end
            if (enq) begin
                tail_next = tail_reg + PTR_W'(1);
            end
            if (enq && !deq) begin
                count_next = count_reg + CNT_W'(1);
            end else if (deq && !enq) begin
                count_next = count_reg - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Entry storage is never reset; only slots between head and tail are ever observed.
    always_ff @(posedge clock) begin
        if (enq) begin
            mem[tail_reg] <= '{inst: if_id_packet_in.inst,
                               PC:   if_id_packet_in.PC,
                               NPC:  if_id_packet_in.NPC};
        end
    end

    always_comb begin
        if_id_packet_out.valid = 1'b0;
        if_id_packet_out.inst  = NOP_INST;
        if_id_packet_out.PC    = '0;
        if_id_packet_out.NPC   = '0;
        if (!empty) begin
            if_id_packet_out.valid = 1'b1;
            if_id_packet_out.inst  = mem[head_reg].inst;
            if_id_packet_out.PC    = mem[head_reg].PC;
            if_id_packet_out.NPC   = mem[head_reg].NPC;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: ordering, full back-pressure, wrap, squash, async reset.
`timescale 1ns/1ps

module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clock;
    logic             reset;
    IF_ID_PACKET      pkt_in;
    logic             struc_hazard;
    logic             squash;
    IF_ID_PACKET      pkt_out;
    logic             fetch_stall;
    logic [CNT_W-1:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model[$];
    logic [31:0] drained[$];
    logic        last_enq;

    fetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock           (clock),
        .reset           (reset),
        .if_id_packet_in (pkt_in),
        .struc_hazard    (struc_hazard),
        .squash          (squash),
        .if_id_packet_out(pkt_out),
        .fetch_stall     (fetch_stall),
        .count           (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic IF_ID_PACKET mk(input logic [31:0] pc);
        IF_ID_PACKET p;
        p.valid = 1'b1;
        p.inst  = 32'hA500_0000 ^ pc;
        p.PC    = pc;
        p.NPC   = pc + 32'd4;
        return p;
    endfunction

    // Compare every output against the reference queue contents.
    task automatic check_outputs(input string tag);
        int sz;
        IF_ID_PACKET e;
        sz = model.size();
        if (sz > 0) e = mk(model[0]);
        else begin
            e.valid = 1'b0; e.inst = NOP_INST; e.PC = '0; e.NPC = '0;
        end
        check({tag, "_count"}, 64'(count), 64'(sz));
        check({tag, "_stall"}, 64'(fetch_stall), 64'(sz == DEPTH));
        check({tag, "_valid"}, 64'(pkt_out.valid), 64'(e.valid));
        check({tag, "_inst"},  64'(pkt_out.inst),  64'(e.inst));
        check({tag, "_pc"},    64'(pkt_out.PC),    64'(e.PC));
        check({tag, "_npc"},   64'(pkt_out.NPC),   64'(e.NPC));
    endtask

    // One clock: decide expected enq/deq from pre-edge state, then sample 2ns after the edge.
    task automatic tick(input string tag);
        logic do_deq, do_enq;
        logic [31:0] head_pc;
        do_deq  = (model.size() > 0) && !struc_hazard && !squash;
        do_enq  = pkt_in.valid && (model.size() != DEPTH) && !squash;
        head_pc = pkt_out.PC;
        @(posedge clock);
        #2;
        if (squash) model.delete();
        else begin
            if (do_deq) begin
                void'(model.pop_front());
                drained.push_back(head_pc);
            end
            if (do_enq) model.push_back(pkt_in.PC);
        end
        last_enq = do_enq;
        check_outputs(tag);
    endtask

    initial begin
        int sent;
        int maxc;
        reset        = 1'b1;
        pkt_in       = '0;
        struc_hazard = 1'b0;
        squash       = 1'b0;
        last_enq     = 1'b0;
        @(posedge clock);
        #2;
        check_outputs("reset");
        reset = 1'b0;

        // Three back-to-back packets with no hazard
        pkt_in = mk(32'h0);
        tick("t1_a");
        check("t1_pc0", 64'(pkt_out.PC), 64'h0);
        pkt_in = mk(32'h4);
        tick("t1_b");
        check("t1_pc4", 64'(pkt_out.PC), 64'h4);
        pkt_in = mk(32'h8);
        tick("t1_c");
        check("t1_pc8", 64'(pkt_out.PC), 64'h8);
        pkt_in = '0;
        tick("t1_d");
        check("t1_empty_inst", 64'(pkt_out.inst), 64'h13);
        check("t1_empty_cnt", 64'(count), 64'd0);

        // Fill under hazard, hold a 9th, then drain
        struc_hazard = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            pkt_in = mk(32'h200 + 32'(i * 4));
            tick("t2_fill");
        end
        check("t2_full_cnt", 64'(count), 64'd8);
        check("t2_full_stall", 64'(fetch_stall), 64'd1);
        pkt_in = mk(32'h300);
        tick("t2_hold");
        check("t2_hold_cnt", 64'(count), 64'd8);
        drained.delete();
        struc_hazard = 1'b0;
        tick("t2_deq1");
        check("t2_deq1_cnt", 64'(count), 64'd7);
        check("t2_deq1_stall", 64'(fetch_stall), 64'd0);
        tick("t2_enq9");
        check("t2_enq9_taken", 64'(last_enq), 64'd1);
        check("t2_enq9_cnt", 64'(count), 64'd7);
        pkt_in = '0;
        for (int i = 0; i < DEPTH; i++) tick("t2_drain");
        check("t2_drained_n", 64'(drained.size()), 64'd9);
        for (int i = 0; i < 9 && i < drained.size(); i++)
            check($sformatf("t2_order%0d", i), 64'(drained[i]),
                  (i < 8) ? 64'(32'h200 + 32'(i * 4)) : 64'h300);

        // Wrap-around with hazard toggling every 3 cycles
        drained.delete();
        sent = 0;
        maxc = 0;
        for (int cyc = 0; cyc < 200 && (sent < 20 || model.size() > 0); cyc++) begin
            struc_hazard = ((cyc / 3) % 2) == 0;
            pkt_in = (sent < 20) ? mk(32'h1000 + 32'(sent * 4)) : '0;
            tick("wrap");
            if (last_enq) sent++;
            if (int'(count) > maxc) maxc = int'(count);
        end
        check("wrap_done", 64'(sent == 20 && model.size() == 0), 64'd1);
        check("wrap_drained_n", 64'(drained.size()), 64'd20);
        for (int i = 0; i < 20 && i < drained.size(); i++)
            check($sformatf("wrap_order%0d", i), 64'(drained[i]), 64'(32'h1000 + 32'(i * 4)));
        check("wrap_max_le_depth", 64'(maxc <= DEPTH), 64'd1);

        // Squash with 5 buffered and a valid packet in the squash cycle
        pkt_in = '0;
        struc_hazard = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pkt_in = mk(32'h400 + 32'(i * 4));
            tick("t4_fill");
        end
        check("t4_five", 64'(count), 64'd5);
        pkt_in = mk(32'h500);
        squash = 1'b1;
        tick("t4_squash");
        check("t4_sq_cnt", 64'(count), 64'd0);
        check("t4_sq_valid", 64'(pkt_out.valid), 64'd0);
        check("t4_sq_stall", 64'(fetch_stall), 64'd0);
        squash = 1'b0;
        struc_hazard = 1'b0;
        pkt_in = mk(32'h600);
        tick("t4_refetch");
        check("t4_refetch_pc", 64'(pkt_out.PC), 64'h600);
        pkt_in = '0;
        tick("t4_empty");

        // Asynchronous reset mid-cycle with 4 buffered
        struc_hazard = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pkt_in = mk(32'h800 + 32'(i * 4));
            tick("t6_fill");
        end
        check("t6_four", 64'(count), 64'd4);
        pkt_in = '0;
        #1 reset = 1'b1;
        #1;
        model.delete();
        check_outputs("t6_async");
        #1 reset = 1'b0;
        tick("t6_post");
        struc_hazard = 1'b0;
        pkt_in = mk(32'h700);
        tick("t6_resume");
        check("t6_resume_pc", 64'(pkt_out.PC), 64'h700);
        pkt_in = '0;
        tick("t6_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
